// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of a binary producer index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-grant beat counter.
  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority encoder: first set req bit scanning upward from last+1,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // One spare bit so last+1+offset (at most 2*NUM_REQ-1) never overflows.
  localparam int SW = IW + 1;

  logic [2*NUM_REQ-1:0] req2;
  logic [2*NUM_REQ-1:0] req_shift;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SW-1:0]        start;
  logic [SW-1:0]        offset;
  logic [SW-1:0]        sum;

  // Rotate req so bit 0 is the candidate right after last, then find the first set bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and no latch is inferred.
    found     = 1'b0;
    offset    = '0;
    start     = SW'(last) + SW'(1);
    req2      = {req, req};
    req_shift = req2 >> start;
    req_rot   = req_shift[NUM_REQ-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = SW'(k);
      end
    end
    sum = start + offset;
    if (sum >= SW'(NUM_REQ)) begin
      sum = sum - SW'(NUM_REQ);
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bounded bursts of up to MAX_BURST beats and stalling on FIFO full.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full_n,
  output logic                       write_en,
  output logic [WIDTH-1:0]           data_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [CW-1:0] beat_cnt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          owner_req;
  logic          accept;
  logic          last_beat;
  logic          release_burst;

  // In BURST, last always equals owner, so one picker serves both the idle
  // decision and the release hand-off with rotation after the current owner.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy          = (state == BURST);
  assign owner_req     = req[owner];
  assign accept        = busy && owner_req && fifo_full_n && !rst;
  assign write_en      = accept;
  assign last_beat     = (beat_cnt == CW'(MAX_BURST - 1));
  // A dropped req releases even when the FIFO is full; that cycle writes nothing.
  assign release_burst = busy && (!owner_req || (accept && last_beat));
  assign grant_id      = busy ? owner : '0;

  // Decode the registered owner into one-hot grant and the owner's ready bit.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    if (busy) begin
      grant[owner] = 1'b1;
      if (!rst) begin
        req_ready[owner] = fifo_full_n;
      end
    end
  end

  // Steer the owner's data slice to the FIFO; selection depends only on owner.
  always_comb begin
    data_in = '0;
    if (busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == IW'(i)) begin
          data_in = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Arbitration FSM: grant, count beats, release and re-arbitrate without a bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BURST;
            owner    <= pick_idx;
            last     <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (release_burst) begin
            if (pick_found) begin
              owner    <= pick_idx;
              last     <= pick_idx;
              beat_cnt <= '0;
            end else begin
              state    <= IDLE;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: producer model with per-producer data
// sequences, per-cycle protocol checks and scenario-specific trace checks.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;
  localparam int TL = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full_n;
  logic           write_en;
  logic [W-1:0]   data_in;
  logic [N-1:0]   grant;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full_n (fifo_full_n),
    .write_en    (write_en),
    .data_in     (data_in),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Producer model: producer i offers base[i]+ptr[i] while ptr[i] < len[i].
  int          len[N];
  logic [31:0] base[N];
  int          ptr[N];
  int          wr_cnt[N];
  int          cyc;
  int          full_from;
  int          full_to;
  int          rst_cyc;

  logic        tr_we[TL];
  logic [3:0]  tr_grant[TL];
  logic [31:0] tr_data[TL];
  logic        tr_busy[TL];
  logic [1:0]  tr_gid[TL];

  task automatic drive();
    rst         = (cyc == rst_cyc);
    fifo_full_n = !(cyc >= full_from && cyc <= full_to);
    for (int i = 0; i < N; i++) begin
      req[i]               = (ptr[i] < len[i]);
      req_data[i*W +: W]   = base[i] + 32'(ptr[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      len[i] = 0; base[i] = '0; ptr[i] = 0; wr_cnt[i] = 0;
    end
    full_from = -1; full_to = -2; rst_cyc = -1; cyc = 0;
    for (int k = 0; k < TL; k++) begin
      tr_we[k] = 1'b0; tr_grant[k] = '0; tr_data[k] = '0; tr_busy[k] = 1'b0; tr_gid[k] = '0;
    end
  endtask

  // Two-cycle reset with all producers requesting; outputs must already be idle.
  task automatic do_reset();
    rst = 1'b1; req = '1; req_data = {N{32'hDEAD_BEEF}}; fifo_full_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(write_en), 32'h0);
    check("rst_data", data_in, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int ncyc);
    logic [N-1:0] hs;
    logic [N-1:0] exp_ready;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      hs = req & req_ready;
      if (cyc < TL) begin
        tr_we[cyc] = write_en; tr_grant[cyc] = grant; tr_data[cyc] = data_in;
        tr_busy[cyc] = busy; tr_gid[cyc] = grant_id;
      end
      check("onehot", 32'($countones(grant) <= 1), 32'h1);
      exp_ready = (busy && !rst) ? (grant & {N{fifo_full_n}}) : '0;
      check("ready", 32'(req_ready), 32'(exp_ready));
      check("hs_we", 32'(write_en), 32'(|hs));
      if (write_en) begin
        check("wdata", data_in, base[grant_id] + 32'(ptr[grant_id]));
        wr_cnt[grant_id]++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) ptr[i]++;
      cyc++;
      drive();
    end
  endtask

  initial begin
    int exp_own[5];
    exp_own = '{0, 1, 2, 3, 0};

    // Single producer, 6 beats: burst of 4, immediate re-grant, 2 more, no bubble.
    clear_model();
    do_reset();
    len[0] = 6; base[0] = 32'hA0;
    drive();
    run(10);
    check("s1_idle_c0", 32'(tr_grant[0]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      check("s1_grant", 32'(tr_grant[k]), 32'h1);
      check("s1_we", 32'(tr_we[k]), 32'h1);
      check("s1_data", tr_data[k], 32'hA0 + 32'(k - 1));
    end
    check("s1_no_extra", 32'(tr_we[7]), 32'h0);
    check("s1_cnt0", 32'(wr_cnt[0]), 32'd6);

    // All four requesting: grant order 0,1,2,3,0, four beats each, gapless.
    clear_model();
    do_reset();
    for (int i = 0; i < N; i++) begin
      len[i] = 8; base[i] = 32'h100 * 32'(i + 1);
    end
    drive();
    run(36);
    for (int s = 0; s < 5; s++) begin
      for (int b = 0; b < MB; b++) begin
        check("s2_grant", 32'(tr_grant[1 + s*MB + b]), 32'h1 << exp_own[s]);
        check("s2_we", 32'(tr_we[1 + s*MB + b]), 32'h1);
      end
    end
    for (int i = 0; i < N; i++) check("s2_cnt", 32'(wr_cnt[i]), 32'd8);

    // Owner 1 drops after 2 beats while producer 3 waits.
    clear_model();
    do_reset();
    len[1] = 2; base[1] = 32'hB0;
    len[3] = 4; base[3] = 32'hD0;
    drive();
    run(12);
    check("s3_g1", 32'(tr_grant[1]), 32'h2);
    check("s3_we1", 32'(tr_we[1]), 32'h1);
    check("s3_g2", 32'(tr_grant[2]), 32'h2);
    check("s3_we2", 32'(tr_we[2]), 32'h1);
    check("s3_g3", 32'(tr_grant[3]), 32'h2);
    check("s3_we3", 32'(tr_we[3]), 32'h0);
    check("s3_g4", 32'(tr_grant[4]), 32'h8);
    check("s3_we4", 32'(tr_we[4]), 32'h1);
    check("s3_cnt1", 32'(wr_cnt[1]), 32'd2);
    check("s3_cnt3", 32'(wr_cnt[3]), 32'd4);

    // FIFO full for 3 cycles with two beats already written by owner 2.
    clear_model();
    do_reset();
    len[2] = 6; base[2] = 32'hC0;
    len[3] = 2; base[3] = 32'hE0;
    full_from = 3; full_to = 5;
    drive();
    run(14);
    for (int k = 3; k <= 5; k++) begin
      check("s4_full_we", 32'(tr_we[k]), 32'h0);
      check("s4_full_grant", 32'(tr_grant[k]), 32'h4);
    end
    check("s4_we6", 32'(tr_we[6]), 32'h1);
    check("s4_d6", tr_data[6], 32'hC2);
    check("s4_we7", 32'(tr_we[7]), 32'h1);
    check("s4_d7", tr_data[7], 32'hC3);
    check("s4_g8", 32'(tr_grant[8]), 32'h8);
    check("s4_cnt2", 32'(wr_cnt[2]), 32'd6);
    check("s4_cnt3", 32'(wr_cnt[3]), 32'd2);

    // Reset mid-burst on owner 2, then owner 2 re-granted ahead of idle producer 0.
    clear_model();
    do_reset();
    len[2] = 8; base[2] = 32'hF0;
    rst_cyc = 3;
    drive();
    run(12);
    check("s5_we_rst", 32'(tr_we[3]), 32'h0);
    check("s5_g_rst", 32'(tr_grant[3]), 32'h4);
    check("s5_g_after", 32'(tr_grant[4]), 32'h0);
    check("s5_busy_after", 32'(tr_busy[4]), 32'h0);
    check("s5_gid_after", 32'(tr_gid[4]), 32'h0);
    check("s5_data_after", tr_data[4], 32'h0);
    check("s5_regrant", 32'(tr_grant[5]), 32'h4);
    check("s5_resume", tr_data[5], 32'hF2);
    check("s5_cnt2", 32'(wr_cnt[2]), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO and drives `write_en`/`data_in` from the granted producer. It grants in bounded bursts of up to `MAX_BURST` beats and honours the FIFO's active-low full flag, so no beat is ever dropped or duplicated.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..8)
- `WIDTH`, 32, data width; matches FIFO `WIDTH`
- `MAX_BURST`, 4, maximum beats per grant (1..16)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  `NUM_REQ`  per-producer valid; bit i high = producer i has a beat to write
- `req_data`  in  `NUM_REQ*WIDTH`  producer i data in bits `[i*WIDTH +: WIDTH]`
- `req_ready`  out  `NUM_REQ`  per-producer accept; beat i transfers when `req[i] && req_ready[i]`
- `fifo_full_n`  in  1  FIFO full flag, active low (0 = full)
- `write_en`  out  1  FIFO write strobe
- `data_in`  out  `WIDTH`  FIFO write data
- `grant`  out  `NUM_REQ`  one-hot current owner; all-zero when idle
- `grant_id`  out  `$clog2(NUM_REQ)`  binary owner index; 0 when idle
- `busy`  out  1  high in `BURST` state

## Operation
- FSM states: `IDLE`, `BURST`. Registered: `state`, `owner`, `beat_cnt`, and `last` (index of the most recent owner).
- Pick function: the first `req` bit set, scanning from `last+1` upward with wrap modulo `NUM_REQ`.
- `IDLE`: if any `req` bit is set, register `owner` = pick, set `last` = pick, clear `beat_cnt`, go to `BURST`. No write occurs in `IDLE`.
- `BURST`:
  - `req_ready[owner] = fifo_full_n`. All other `req_ready` bits are 0.
  - `write_en = req[owner] && fifo_full_n`.
  - `data_in` = the owner's slice of `req_data`. When `write_en` is 0, `data_in` is don't-care but is held at the owner's slice.
- Accepted beat: `beat_cnt` increments.
- Release condition:
  - `req[owner]` is low, or
  - a beat is accepted while `beat_cnt == MAX_BURST-1`.
- On release, re-arbitrate in the same cycle, with rotation starting after the releasing owner.
  - If any `req` bit is set: load the new owner, clear `beat_cnt`, stay in `BURST`. There is no bubble.
  - If none is set: go to `IDLE`.
- When the releasing owner is the only requester, it is re-granted immediately.
- FIFO full (`fifo_full_n` = 0) while granted: `write_en` = 0 and `beat_cnt` holds. The grant is held indefinitely; there is no timeout and no release on full.
- Release by `req` drop and full can coincide. The `req` drop wins, and no write occurs that cycle.
- `beat_cnt` width is `$clog2(MAX_BURST)+1`. It never exceeds `MAX_BURST-1`. With `MAX_BURST=1`, every accepted beat releases.

## Timing
- Reset values:
  - `state` = `IDLE`, `owner` = 0, `beat_cnt` = 0, `last` = `NUM_REQ-1`, so producer 0 wins first after reset.
  - Outputs: `grant`=0, `grant_id`=0, `busy`=0, `req_ready`=0, `write_en`=0, `data_in`=0.
- While `rst` is high, `write_en` and `req_ready` are forced to 0 combinationally.
- Reset mid-burst aborts the burst. The cycle in which `rst` is sampled writes nothing.
- Latency:
  - `req` rise in `IDLE` to `grant`: 1 cycle.
  - First write: the same cycle `grant` appears, if `fifo_full_n` = 1.
- Handoff between owners adds 0 cycles.
- `write_en`, `req_ready` and `data_in` are combinational from registered owner state plus `req`/`fifo_full_n`. There is no path from `req_data` to control.
- Throughput: 1 beat/cycle while the FIFO is not full.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `BURST`).
  - Localparam functions for index and counter widths.
- Sub-module `rr_pick`: combinational rotating-priority encoder.
  - Inputs: `req`, `last`.
  - Outputs: `found`, `idx`.
  - Instantiated once and used for both the `IDLE` and release decisions.

## Test plan
- Reset, then `req`=4'b0001 with data 0xA0..0xA5 and FIFO never full.
  - `grant`=0001 next cycle.
  - Writes 0xA0..0xA3 on consecutive cycles.
  - Release after 4 beats, immediate re-grant to 0, remaining beats written with no bubble.
- `req`=4'b1111 held, `MAX_BURST`=4: grant order 0,1,2,3,0. Each owner writes exactly 4 beats, and 16 consecutive `write_en` cycles occur with no gap.
- Owner 1 drops `req` after 2 beats while `req[3]`=1: 2 writes from 1, then owner 3 in the following cycle.
- `fifo_full_n`=0 for 3 cycles mid-burst at `beat_cnt`=2.
  - `write_en`=0 and grant held.
  - `beat_cnt` stays 2.
  - On `fifo_full_n`=1, 2 more beats are written, then release.
- `rst` asserted mid-burst on owner 2.
  - `write_en`=0 that cycle; all outputs reach reset values at the next edge.
  - With `req`=4'b0100, owner 0 is skipped and 2 is re-granted.
- Scoreboard across all scenarios: FIFO contents equal per-producer order with no loss or duplication, and `popcount(grant)`≤1 every cycle.
